// File: rtl/aes_rk_pkg.sv
// Shared types and defaults for the AES round-key sequencer.
// Optional decrypt ordering is enabled by defining AES_RK_REVERSE_EN.
package aes_rk_pkg;

    localparam int DEF_NUM_KEYS = 11;
    localparam int DEF_IDX_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } rk_state_e;

    typedef struct packed {
        logic [63:0] higher;
        logic [63:0] lower;
    } block_t;

endpackage

// File: rtl/aes_rk_key_file.sv
// Round-key register file: one synchronous write port, one async read port.
// Contents are deliberately not reset; slot range is checked on writes.
module aes_rk_key_file
    import aes_rk_pkg::*;
#(
    parameter int NUM_KEYS = DEF_NUM_KEYS,
    parameter int IDX_W    = DEF_IDX_W
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [127:0]       wr_data,
    output logic               wr_idx_ok,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic [127:0]       rd_data
);

    localparam logic [IDX_W:0] KEY_CNT = (IDX_W+1)'(NUM_KEYS);

    block_t keys [NUM_KEYS];

    assign wr_idx_ok = {1'b0, wr_idx} < KEY_CNT;

    always_ff @(posedge clk) begin
        if (wr_en && wr_idx_ok) begin
            keys[wr_idx] <= block_t'(wr_data);
        end
    end

    assign rd_data = keys[rd_idx];

endmodule

// File: rtl/aes_round_key_sequencer.sv
// Walks one 128-bit block through the add-round-key datapath for every key.
// Define AES_RK_REVERSE_EN to add i_reverse (descending key order for decrypt).
module aes_round_key_sequencer
    import aes_rk_pkg::*;
#(
    parameter int NUM_KEYS = DEF_NUM_KEYS,
    parameter int IDX_W    = DEF_IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_wr_en,
    input  logic [IDX_W-1:0]  key_wr_idx,
    input  logic [63:0]       key_wr_higher,
    input  logic [63:0]       key_wr_lower,
    output logic              key_wr_err,
    input  logic              i_valid,
    output logic              i_ready,
    input  logic [63:0]       i_data_higher,
    input  logic [63:0]       i_data_lower,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [63:0]       o_data_higher,
    output logic [63:0]       o_data_lower,
    output logic              dp_valid,
    input  logic              dp_ready,
    output logic [63:0]       dp_data_higher,
    output logic [63:0]       dp_data_lower,
    output logic [63:0]       dp_key_higher,
    output logic [63:0]       dp_key_lower,
    input  logic              dp_res_valid,
    output logic              dp_res_ready,
    input  logic [63:0]       dp_res_higher,
    input  logic [63:0]       dp_res_lower,
`ifdef AES_RK_REVERSE_EN
    input  logic              i_reverse,
`endif
    output logic              busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_KEYS - 1);
    localparam logic [IDX_W-1:0] ONE      = IDX_W'(1);

    rk_state_e        state_q;
    rk_state_e        state_d;
    logic [IDX_W-1:0] round_q;
    logic [IDX_W-1:0] start_idx;
    logic [IDX_W-1:0] next_idx;
    block_t           blk_q;
    block_t           key_rd;
    logic             err_q;
    logic             idle;
    logic             accept;
    logic             capture;
    logic             last_rnd;
    logic             idx_ok;

    assign idle    = (state_q == ST_IDLE);
    assign accept  = idle && i_valid;
    assign capture = dp_res_valid && dp_res_ready;

`ifdef AES_RK_REVERSE_EN
    logic rev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rev_q <= 1'b0;
        end else if (accept) begin
            rev_q <= i_reverse;
        end
    end

    assign start_idx = i_reverse ? LAST_IDX : '0;
    assign last_rnd  = rev_q ? (round_q == '0) : (round_q == LAST_IDX);
    assign next_idx  = rev_q ? (round_q - ONE) : (round_q + ONE);
`else
    assign start_idx = '0;
    assign last_rnd  = (round_q == LAST_IDX);
    assign next_idx  = round_q + ONE;
`endif

    aes_rk_key_file #(
        .NUM_KEYS (NUM_KEYS),
        .IDX_W    (IDX_W)
    ) u_key_file (
        .clk       (clk),
        .wr_en     (key_wr_en && idle),
        .wr_idx    (key_wr_idx),
        .wr_data   ({key_wr_higher, key_wr_lower}),
        .wr_idx_ok (idx_ok),
        .rd_idx    (round_q),
        .rd_data   (key_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A combinational datapath may return the result in the issue cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_valid) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (dp_ready) begin
                    if (!dp_res_valid) state_d = ST_WAIT;
                    else if (last_rnd) state_d = ST_DONE;
                end
            end
            ST_WAIT: begin
                if (dp_res_valid) begin
                    state_d = last_rnd ? ST_DONE : ST_ISSUE;
                end
            end
            ST_DONE: begin
                if (o_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        i_ready      = 1'b0;
        dp_valid     = 1'b0;
        dp_res_ready = 1'b0;
        o_valid      = 1'b0;
        busy         = 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                i_ready = 1'b1;
                busy    = 1'b0;
            end
            ST_ISSUE: begin
                dp_valid     = 1'b1;
                dp_res_ready = dp_ready;
            end
            ST_WAIT: dp_res_ready = 1'b1;
            ST_DONE: o_valid      = 1'b1;
            default: busy         = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            round_q <= '0;
            blk_q   <= '0;
        end else if (accept) begin
            round_q <= start_idx;
            blk_q   <= block_t'({i_data_higher, i_data_lower});
        end else if (capture) begin
            blk_q <= block_t'({dp_res_higher, dp_res_lower});
            if (!last_rnd) round_q <= next_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= key_wr_en && !(idle && idx_ok);
        end
    end

    assign key_wr_err     = err_q;
    assign dp_data_higher = blk_q.higher;
    assign dp_data_lower  = blk_q.lower;
    assign dp_key_higher  = key_rd.higher;
    assign dp_key_lower   = key_rd.lower;
    assign o_data_higher  = blk_q.higher;
    assign o_data_lower   = blk_q.lower;

endmodule
